// File: rtl/ub_pkg.sv
// Shared types and constants for the unified-buffer read path.
package ub_pkg;

   localparam int UB_DEPTH = 50;
   localparam int ADDR_W   = 6;
   localparam int DATA_W   = 16;

   typedef logic [ADDR_W-1:0] ub_addr_t;
   typedef logic [DATA_W-1:0] ub_data_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } ub_state_e;

endpackage

// File: rtl/ub_lane_skew.sv
// One-stage delay of a lane's data and valid; supplies the systolic diagonal skew.
module ub_lane_skew
   import ub_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     valid_i,
   input  ub_data_t data_i,
   output logic     valid_o,
   output ub_data_t data_o
);

   logic     valid_q;
   ub_data_t data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_i;
         data_q  <= data_i;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/ub_read_sequencer.sv
// Walks a unified-buffer region in row or column order and streams it on two lanes.
// Define UB_READ_SKEW_EN to delay lane2 by one cycle relative to lane1.
module ub_read_sequencer
   import ub_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      rd_start_in,
   input  logic      rd_row_or_col_in,
   input  ub_addr_t  rd_base_addr_in,
   input  ub_addr_t  rd_num_locs_in,
   output logic      mem_rd_en_out,
   output ub_addr_t  mem_rd_addr_1_out,
   output ub_addr_t  mem_rd_addr_2_out,
   input  ub_data_t  mem_rd_data_1_in,
   input  ub_data_t  mem_rd_data_2_in,
   output ub_data_t  ub_data_1_out,
   output ub_data_t  ub_data_2_out,
   output logic      ub_valid_1_out,
   output logic      ub_valid_2_out,
   output logic      rd_busy_out,
   output logic      rd_done_out,
   output logic      rd_err_out,
   output ub_state_e dbg_state_out
);

`ifdef UB_READ_SKEW_EN
   localparam logic [1:0] DRAIN_LAST = 2'd3;
`else
   localparam logic [1:0] DRAIN_LAST = 2'd2;
`endif

   ub_state_e state_q, state_d;
   ub_addr_t  base_q, base_d;
   ub_addr_t  num_q, num_d;
   ub_addr_t  half_q, half_d;
   ub_addr_t  beats_q, beats_d;
   ub_addr_t  k_q, k_d;
   logic      col_q, col_d;
   logic [1:0] drain_q, drain_d;
   logic      err_q, err_d;

   logic      rd_en;
   logic      lane2_en;
   ub_addr_t  addr1, addr2;
   logic      done;

   logic      pend1_q, pend2_q;
   logic      v1_q, v2_q;
   ub_data_t  d1_q, d2_q;

   // Sum is widened so a base near the top plus a large count cannot wrap past the check.
   logic [6:0] end_sum;
   logic       cmd_illegal;
   ub_addr_t   cmd_beats;
   ub_addr_t   row_off;

   assign end_sum     = {1'b0, rd_base_addr_in} + {1'b0, rd_num_locs_in};
   assign cmd_illegal = (end_sum > 7'(UB_DEPTH)) || (rd_row_or_col_in && rd_num_locs_in[0]);
   assign cmd_beats   = rd_row_or_col_in ? {1'b0, rd_num_locs_in[5:1]}
                                         : ({1'b0, rd_num_locs_in[5:1]} + {5'd0, rd_num_locs_in[0]});
   assign row_off     = {k_q[4:0], 1'b0};

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      num_d    = num_q;
      half_d   = half_q;
      beats_d  = beats_q;
      col_d    = col_q;
      k_d      = k_q;
      drain_d  = drain_q;
      err_d    = 1'b0;
      rd_en    = 1'b0;
      lane2_en = 1'b0;
      addr1    = '0;
      addr2    = '0;
      done     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (rd_start_in) begin
               if (cmd_illegal) begin
                  err_d = 1'b1;
               end else begin
                  base_d  = rd_base_addr_in;
                  num_d   = rd_num_locs_in;
                  half_d  = {1'b0, rd_num_locs_in[5:1]};
                  beats_d = cmd_beats;
                  col_d   = rd_row_or_col_in;
                  k_d     = '0;
                  if (cmd_beats == '0) begin
                     state_d = ST_DRAIN;
                     drain_d = DRAIN_LAST;
                  end else begin
                     state_d = ST_ISSUE;
                     drain_d = '0;
                  end
               end
            end
         end
         ST_ISSUE: begin
            rd_en = 1'b1;
            if (col_q) begin
               lane2_en = 1'b1;
               addr1    = base_q + k_q;
               addr2    = base_q + half_q + k_q;
            end else begin
               // Odd row counts leave lane2 idle on the last beat.
               lane2_en = (row_off + 6'd1) < num_q;
               addr1    = base_q + row_off;
               addr2    = lane2_en ? (base_q + row_off + 6'd1) : '0;
            end
            k_d = k_q + 6'd1;
            if (k_q == beats_q - 6'd1) begin
               state_d = ST_DRAIN;
               drain_d = '0;
            end
         end
         ST_DRAIN: begin
            if (drain_q == DRAIN_LAST) begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end else begin
               drain_d = drain_q + 2'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         base_q  <= '0;
         num_q   <= '0;
         half_q  <= '0;
         beats_q <= '0;
         col_q   <= 1'b0;
         k_q     <= '0;
         drain_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         num_q   <= num_d;
         half_q  <= half_d;
         beats_q <= beats_d;
         col_q   <= col_d;
         k_q     <= k_d;
         drain_q <= drain_d;
         err_q   <= err_d;
      end
   end

   // Read data arrives the cycle after the strobe and is registered once more on capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend1_q <= 1'b0;
         pend2_q <= 1'b0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         d1_q    <= '0;
         d2_q    <= '0;
      end else begin
         pend1_q <= rd_en;
         pend2_q <= rd_en & lane2_en;
         v1_q    <= pend1_q;
         v2_q    <= pend2_q;
         d1_q    <= pend1_q ? mem_rd_data_1_in : '0;
         d2_q    <= pend2_q ? mem_rd_data_2_in : '0;
      end
   end

`ifdef UB_READ_SKEW_EN
   ub_lane_skew u_lane2_skew (
      .clk     (clk),
      .rst     (rst),
      .valid_i (v2_q),
      .data_i  (d2_q),
      .valid_o (ub_valid_2_out),
      .data_o  (ub_data_2_out)
   );
`else
   assign ub_valid_2_out = v2_q;
   assign ub_data_2_out  = d2_q;
`endif

   assign ub_valid_1_out    = v1_q;
   assign ub_data_1_out     = d1_q;
   assign mem_rd_en_out     = rd_en;
   assign mem_rd_addr_1_out = addr1;
   assign mem_rd_addr_2_out = addr2;
   assign rd_busy_out       = (state_q != ST_IDLE);
   assign rd_done_out       = done;
   assign rd_err_out        = err_q;
   assign dbg_state_out     = state_q;

endmodule

// File: tb/tb_ub_read_sequencer.sv
// Bench for ub_read_sequencer: per-cycle timeline model built from the command rules.
module tb_ub_read_sequencer;
  import ub_pkg::*;

`ifdef UB_READ_SKEW_EN
  localparam int SKEW = 1;
`else
  localparam int SKEW = 0;
`endif
  localparam int MAXC = 8000;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      rd_start = 1'b0;
  logic      rd_col = 1'b0;
  ub_addr_t  rd_base = '0;
  ub_addr_t  rd_num = '0;
  logic      mem_en;
  ub_addr_t  mem_a1, mem_a2;
  ub_data_t  mem_d1 = '0, mem_d2 = '0;
  ub_data_t  ub_d1, ub_d2;
  logic      ub_v1, ub_v2, busy, done, err;
  ub_state_e dbg_state;

  ub_read_sequencer dut (
    .clk               (clk),
    .rst               (rst),
    .rd_start_in       (rd_start),
    .rd_row_or_col_in  (rd_col),
    .rd_base_addr_in   (rd_base),
    .rd_num_locs_in    (rd_num),
    .mem_rd_en_out     (mem_en),
    .mem_rd_addr_1_out (mem_a1),
    .mem_rd_addr_2_out (mem_a2),
    .mem_rd_data_1_in  (mem_d1),
    .mem_rd_data_2_in  (mem_d2),
    .ub_data_1_out     (ub_d1),
    .ub_data_2_out     (ub_d2),
    .ub_valid_1_out    (ub_v1),
    .ub_valid_2_out    (ub_v2),
    .rd_busy_out       (busy),
    .rd_done_out       (done),
    .rd_err_out        (err),
    .dbg_state_out     (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // buffer model: synchronous read, one cycle latency
  logic [15:0] mem [0:UB_DEPTH-1];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_d1 <= (mem_a1 < UB_DEPTH) ? mem[mem_a1] : 16'hBAD0;
      mem_d2 <= (mem_a2 < UB_DEPTH) ? mem[mem_a2] : 16'hBAD0;
    end
  end

  // scoreboard: expected value of every output, indexed by cycle
  logic        exp_en   [MAXC];
  logic [5:0]  exp_a1   [MAXC];
  logic [5:0]  exp_a2   [MAXC];
  logic        exp_a2_chk [MAXC];
  logic        exp_v1   [MAXC];
  logic        exp_v2   [MAXC];
  logic [15:0] exp_d1   [MAXC];
  logic [15:0] exp_d2   [MAXC];
  logic        exp_busy [MAXC];
  logic        exp_done [MAXC];
  logic        exp_err  [MAXC];
  int          busy_last = -10;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_from(input int c);
    for (int i = c; i < MAXC; i++) begin
      exp_en[i] = 0; exp_a1[i] = 0; exp_a2[i] = 0; exp_a2_chk[i] = 1;
      exp_v1[i] = 0; exp_v2[i] = 0; exp_d1[i] = 0; exp_d2[i] = 0;
      exp_busy[i] = 0; exp_done[i] = 0; exp_err[i] = 0;
    end
  endtask

  // Reference: a start seen at edge e0 produces a fixed timeline from the command alone.
  task automatic model_cmd(input int e0, input bit col, input int base, input int n);
    int nb, p, dc, a1, a2;
    bit has2;
    if (e0 - 1 <= busy_last) return;
    if (base + n > UB_DEPTH || (col && (n % 2 == 1))) begin
      exp_err[e0] = 1;
      return;
    end
    p  = n / 2;
    nb = col ? p : (n + 1) / 2;
    dc = (n == 0) ? e0 : e0 + nb + 2 + SKEW;
    for (int c = e0; c <= dc; c++) exp_busy[c] = 1;
    exp_done[dc] = 1;
    for (int k = 0; k < nb; k++) begin
      a1   = col ? base + k : base + 2 * k;
      a2   = col ? base + p + k : base + 2 * k + 1;
      has2 = col || (2 * k + 1 < n);
      exp_en[e0 + k] = 1;
      exp_a1[e0 + k] = 6'(a1);
      exp_v1[e0 + k + 2] = 1;
      exp_d1[e0 + k + 2] = mem[a1];
      if (has2) begin
        exp_a2[e0 + k] = 6'(a2);
        exp_v2[e0 + k + 2 + SKEW] = 1;
        exp_d2[e0 + k + 2 + SKEW] = mem[a2];
      end else begin
        exp_a2_chk[e0 + k] = 0;
      end
    end
    busy_last = dc;
  endtask

  // driver
  task automatic send(input bit col, input int base, input int n, output int e0);
    @(negedge clk);
    rd_start = 1'b1;
    rd_col   = col;
    rd_base  = 6'(base);
    rd_num   = 6'(n);
    e0 = cyc + 1;
    model_cmd(e0, col, base, n);
    @(negedge clk);
    rd_start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (cyc > busy_last + 1) return;
      @(negedge clk);
    end
    chk("idle_timeout", 32'(cyc), 32'(busy_last + 1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {mem_en, ub_v1, ub_v2, busy, done, err}, 0);
    chk({tag, "_data"}, {ub_d1, ub_d2}, 0);
    chk({tag, "_addr"}, {mem_a1, mem_a2}, 0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // per-cycle compare against the scoreboard
  bit chk_on = 0;
  always @(negedge clk) begin
    if (chk_on && !rst) begin
      chk("rd_en", mem_en, exp_en[cyc]);
      chk("addr1", mem_a1, exp_a1[cyc]);
      if (exp_a2_chk[cyc]) chk("addr2", mem_a2, exp_a2[cyc]);
      if (mem_en) chk("addr_range", 32'(mem_a1 < UB_DEPTH && mem_a2 < UB_DEPTH), 1);
      chk("valid1", ub_v1, exp_v1[cyc]);
      chk("valid2", ub_v2, exp_v2[cyc]);
      chk("data1", ub_d1, exp_d1[cyc]);
      chk("data2", ub_d2, exp_d2[cyc]);
      chk("busy", busy, exp_busy[cyc]);
      chk("done", done, exp_done[cyc]);
      chk("err", err, exp_err[cyc]);
      chk("state_idle", 32'(dbg_state == ST_IDLE), 32'(!exp_busy[cyc]));
    end
  end

  initial begin
    int e0, dummy;
    int col, base, n, gap;
    clear_from(0);
    for (int i = 0; i < UB_DEPTH; i++) mem[i] = 16'(i + 100);

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    chk_on = 1;

    // row, base 4, N=4
    send(0, 4, 4, e0);
    chk("pin_row4_b0", {exp_v1[e0+2], exp_d1[e0+2], exp_d2[e0+2+SKEW]}, {1'b1, 16'd104, 16'd105});
    chk("pin_row4_b1", {exp_d1[e0+3], exp_d2[e0+3+SKEW]}, {16'd106, 16'd107});
    chk("pin_row4_done", exp_done[e0+4+SKEW], 1);
    wait_idle();

    // row, base 10, N=3
    send(0, 10, 3, e0);
    chk("pin_row3", {exp_d1[e0+2], exp_d2[e0+2+SKEW], exp_d1[e0+3], exp_v2[e0+3+SKEW]},
        {16'd110, 16'd111, 16'd112, 1'b0});
    wait_idle();

    // column, base 0, N=6
    send(1, 0, 6, e0);
    chk("pin_col6", {exp_d1[e0+2], exp_d1[e0+4], exp_d2[e0+2+SKEW], exp_d2[e0+4+SKEW]},
        {16'd100, 16'd102, 16'd103, 16'd105});
    chk("pin_col6_done", exp_done[e0+5+SKEW], 1);
    wait_idle();

    // rejected commands
    send(0, 48, 4, e0);
    chk("pin_err_range", {exp_err[e0], exp_busy[e0], exp_en[e0]}, 3'b100);
    wait_idle();
    send(1, 0, 5, e0);
    chk("pin_err_odd", exp_err[e0], 1);
    wait_idle();

    // empty command
    send(0, 7, 0, e0);
    chk("pin_n0", {exp_done[e0], exp_v1[e0+1], exp_v1[e0+2]}, 3'b100);
    wait_idle();

    // second start while busy is dropped
    send(0, 0, 10, e0);
    send(1, 2, 4, dummy);
    send(0, 60, 9, dummy);
    wait_idle();

    // reset in the middle of ISSUE
    send(0, 0, 20, e0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    clear_from(cyc + 1);
    busy_last = -10;
    #1;
    chk_all_zero("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(1, 20, 8, e0);
    wait_idle();

    // randomized commands, including overlaps and illegal ones
    for (int t = 0; t < 150 && cyc < MAXC - 120; t++) begin
      if (cyc > busy_last + 1 && $urandom_range(0, 3) == 0)
        for (int i = 0; i < UB_DEPTH; i++) mem[i] = 16'($urandom);
      col  = $urandom_range(0, 1);
      base = $urandom_range(0, 52);
      n    = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 20);
      send(col[0], base, n, dummy);
      gap = $urandom_range(0, 14);
      repeat (gap) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("end_idle", {busy, mem_en}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ub_read_sequencer.md
# ub_read_sequencer

Read-side controller for the unified buffer. On one start command it walks a contiguous region of unified-buffer memory and streams it onto two 16-bit lanes feeding the systolic array's input/weight accumulators. It supports row order or column order and marks each beat with per-lane valids. It sits between the ISA decode and the buffer's synchronous read port, and mirrors the buffer's two-lane write path.

## Interface
- UB_DEPTH, 50: number of 16-bit buffer locations; addresses are 6 bits.
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- rd_start_in  in  1  command pulse; sampled only in IDLE
- rd_row_or_col_in  in  1  0 = row order, 1 = column order
- rd_base_addr_in  in  6  first location of the region
- rd_num_locs_in  in  6  number of locations N; a count, not an address
- mem_rd_en_out  out  1  read strobe to the buffer
- mem_rd_addr_1_out, mem_rd_addr_2_out  out  6  lane addresses
- mem_rd_data_1_in, mem_rd_data_2_in  in  16  read data, returned 1 cycle after the strobe
- ub_data_1_out, ub_data_2_out  out  16  lane data
- ub_valid_1_out, ub_valid_2_out  out  1  lane valids
- rd_busy_out  out  1  command in progress
- rd_done_out  out  1  one-cycle completion pulse
- rd_err_out  out  1  one-cycle pulse when a command is rejected

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE to ISSUE: rd_start_in is high and the command is legal. The block latches base, N, mode and clears the beat counter k.
- Rejected commands: base+N > UB_DEPTH, or column mode with odd N. The block pulses rd_err_out, stays in IDLE, issues no reads and does not assert done.
- N = 0 is legal: rd_done_out pulses next cycle with no valids.
- Row mode, beat k:
  - lane1 reads base+2k; lane2 reads base+2k+1.
  - Number of beats = ceil(N/2).
  - For odd N, the final beat has lane2 disabled: its address is don't-care and ub_valid_2_out stays low for that beat.
- Column mode, beat k, with P = N/2:
  - lane1 reads base+k; lane2 reads base+P+k.
  - Number of beats = P.
- ISSUE asserts mem_rd_en_out for exactly one cycle per beat, back to back with no gaps. After the last beat it goes to DRAIN.
- DRAIN waits for in-flight data and, with skew, the delayed lane2. It then pulses rd_done_out and returns to IDLE.
- rd_busy_out is high from the accepting edge until the cycle rd_done_out is high, inclusive.
- rd_start_in is ignored while busy, and is not queued.
- Address arithmetic is 7-bit internally so the range check cannot wrap. Issued addresses never reach or exceed UB_DEPTH.
- On reset, including mid-command: state IDLE, counters 0, and all outputs 0 (data, valids, busy, done, err, mem_rd_en, addresses). In-flight reads are discarded.

## Timing
- Edge E0: start accepted.
- Beat k read strobe is high during the cycle after E(k).
- Read data is captured into the output registers, so lane1 data/valid for beat k appears after edge E(k+2). Latency from start to first valid is 2 cycles.
- Outputs hold 0 data and valid low when not valid.
- rd_done_out is high the cycle after the last asserted valid on either lane.

## Configuration
- UB_READ_SKEW_EN defined: lane2 data and valid are delayed one extra cycle relative to lane1, giving the systolic diagonal skew. DRAIN lasts one cycle longer.
- UB_READ_SKEW_EN undefined: both lanes of a beat appear in the same cycle.

## Structure
- Shared package ub_pkg holds:
  - UB_DEPTH default and the 6-bit address typedef;
  - the 16-bit data typedef;
  - the FSM state enum.
- One sub-module, ub_lane_skew: a one-stage data+valid delay with asynchronous reset. It is instantiated on lane2 only under UB_READ_SKEW_EN.

## Test plan
- Row mode, base 4, N=4, no skew, mem[i]=i+100:
  - beats (104,105) then (106,107) on consecutive cycles, first valid 2 cycles after start;
  - done 1 cycle after the last valid.
- Row mode, base 10, N=3: beats (110,111) then (112, valid2=0); done follows.
- Column mode, base 0, N=6, with UB_READ_SKEW_EN:
  - lane1 carries 100,101,102;
  - lane2 carries 103,104,105, each one cycle after its lane1 partner;
  - done after lane2's last valid.
- Illegal commands:
  - base 48, N=4 → err pulse, no mem_rd_en, busy stays low;
  - column mode N=5 → err pulse.
- N=0 → done pulse with no valids. A second start issued mid-command is ignored: exactly one done.
- Assert rst during ISSUE → all outputs 0 immediately, state IDLE; a fresh command afterwards completes correctly.
